game_event_tracker: RTL and testbench

- Producer side of the game state machine's inputs: turns per-pixel object overlaps and the raw fire button into frame-aligned game events.
- Outputs: `ready_up`, alien kills, `all_aliens_dead`, `player_hit`, lives and score.
- Runs in the pixel clock domain beside the object renderers. Collisions accumulate during a frame and commit once per frame on `fsync`.

---
 rtl/game_event_tracker.sv | 197 +++++++++++++++++++
 tb/tb_game_event_tracker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_event_tracker.sv
// Frame-aligned game events from per-pixel overlaps and fire button; collisions commit on fsync.
// Latency: event pulses one cycle after the fsync edge; no backpressure, every commit is taken.
module game_event_tracker #(
    parameter int NUM_ALIENS      = 16,
    parameter int ALIEN_IDX_W     = 4,
    parameter int START_LIVES     = 3,
    parameter int LIVES_W         = 2,
    parameter int POINTS          = 10,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int INVULN_FRAMES   = 60
) (
    input  logic                   pixel_clk,
    input  logic                   rst_n,
    input  logic                   fsync,
    input  logic                   active_obj,
    input  logic [ALIEN_IDX_W-1:0] alien_id,
    input  logic                   active_missile,
    input  logic                   active_paddle,
    input  logic                   fire_btn,
    input  logic                   game_start,
    input  logic                   level_start,
    output logic                   ready_up,
    output logic                   alien_hit,
    output logic [NUM_ALIENS-1:0]  alien_alive,
    output logic                   all_aliens_dead,
    output logic                   player_hit,
    output logic [LIVES_W-1:0]     lives,
    output logic                   no_lives,
    output logic [15:0]            score
);

    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int POP_W = $clog2(NUM_ALIENS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_ARMED_WAIT_RELEASE
    } db_state_t;

    logic [NUM_ALIENS-1:0] r_alien_alive;
    logic [NUM_ALIENS-1:0] r_kill_pend;
    logic                  r_player_pend;
    logic [LIVES_W-1:0]    r_lives;
    logic [15:0]           r_score;
    logic [INV_W-1:0]      r_invuln_cnt;
    logic                  r_alien_hit;
    logic                  r_player_hit;

    logic                  r_fire_meta;
    logic                  r_fire_sync;
    db_state_t             r_db_state;
    logic [CNT_W-1:0]      r_db_cnt;
    logic                  r_ready_up;

    logic [NUM_ALIENS-1:0] w_kill_set;
    logic                  w_player_set;
    logic [POP_W-1:0]      w_pop;
    logic [16:0]           w_points;
    logic [16:0]           w_score_sum;
    logic [15:0]           w_score_next;

    // Ids outside the formation match no bit, so they are dropped without a range check.
    always_comb begin
        w_kill_set = '0;
        for (int i = 0; i < NUM_ALIENS; i++) begin
            w_kill_set[i] = active_missile & active_obj & (int'(alien_id) == i) & r_alien_alive[i];
        end
    end

    assign w_player_set = active_paddle & active_obj & (r_invuln_cnt == '0);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_ALIENS; i++) begin
            w_pop = w_pop + POP_W'(r_kill_pend[i]);
        end
    end

    assign w_points     = 17'(w_pop) * 17'(POINTS);
    assign w_score_sum  = {1'b0, r_score} + w_points;
    assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alien_alive <= '0;
            r_kill_pend   <= '0;
            r_player_pend <= 1'b0;
            r_lives       <= '0;
            r_score       <= '0;
            r_invuln_cnt  <= '0;
            r_alien_hit   <= 1'b0;
            r_player_hit  <= 1'b0;
        end else begin
            r_alien_hit  <= 1'b0;
            r_player_hit <= 1'b0;
            if (game_start) begin
                r_alien_alive <= '1;
                r_kill_pend   <= '0;
                r_player_pend <= 1'b0;
                r_lives       <= LIVES_W'(START_LIVES);
                r_score       <= '0;
                r_invuln_cnt  <= '0;
            end else if (level_start) begin
                r_alien_alive <= '1;
                r_kill_pend   <= '0;
                r_player_pend <= 1'b0;
            end else if (fsync) begin
                r_alien_alive <= r_alien_alive & ~r_kill_pend;
                r_score       <= w_score_next;
                r_alien_hit   <= |r_kill_pend;
                if (r_player_pend && (r_lives != '0)) begin
                    r_lives      <= r_lives - LIVES_W'(1);
                    r_player_hit <= 1'b1;
                    r_invuln_cnt <= INV_W'(INVULN_FRAMES);
                end else if (r_invuln_cnt != '0) begin
                    r_invuln_cnt <= r_invuln_cnt - INV_W'(1);
                end
                // Overlaps seen on the fsync cycle itself start the next frame's pending set.
                r_kill_pend   <= w_kill_set;
                r_player_pend <= w_player_set;
            end else begin
                r_kill_pend   <= r_kill_pend | w_kill_set;
                r_player_pend <= r_player_pend | w_player_set;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fire_meta <= 1'b0;
            r_fire_sync <= 1'b0;
        end else begin
            r_fire_meta <= fire_btn;
            r_fire_sync <= r_fire_meta;
        end
    end

    // Button is only looked at once per frame, which is what makes the count a debounce.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_state <= S_IDLE;
            r_db_cnt   <= '0;
            r_ready_up <= 1'b0;
        end else begin
            r_ready_up <= 1'b0;
            if (fsync) begin
                case (r_db_state)
                    S_IDLE: begin
                        if (r_fire_sync) begin
                            if (DEBOUNCE_FRAMES <= 1) begin
                                r_ready_up <= 1'b1;
                                r_db_state <= S_ARMED_WAIT_RELEASE;
                                r_db_cnt   <= '0;
                            end else begin
                                r_db_state <= S_COUNT;
                                r_db_cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    S_COUNT: begin
                        if (!r_fire_sync) begin
                            r_db_state <= S_IDLE;
                            r_db_cnt   <= '0;
                        end else if (r_db_cnt == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                            r_ready_up <= 1'b1;
                            r_db_state <= S_ARMED_WAIT_RELEASE;
                            r_db_cnt   <= '0;
                        end else begin
                            r_db_cnt <= r_db_cnt + CNT_W'(1);
                        end
                    end
                    S_ARMED_WAIT_RELEASE: begin
                        if (!r_fire_sync) begin
                            r_db_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_db_state <= S_IDLE;
                        r_db_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign ready_up        = r_ready_up;
    assign alien_hit       = r_alien_hit;
    assign alien_alive     = r_alien_alive;
    assign all_aliens_dead = (r_alien_alive == '0);
    assign player_hit      = r_player_hit;
    assign lives           = r_lives;
    assign no_lives        = (r_lives == '0);
    assign score           = r_score;

endmodule

// File: tb/tb_game_event_tracker.sv
// Directed bench for game_event_tracker: kills, score saturation, lives/invulnerability, debounce, reset.
module tb_game_event_tracker;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic        fsync;
    logic        active_obj;
    logic [3:0]  alien_id;
    logic        active_missile;
    logic        active_paddle;
    logic        fire_btn;
    logic        game_start;
    logic        level_start;
    logic        ready_up;
    logic        alien_hit;
    logic [15:0] alien_alive;
    logic        all_aliens_dead;
    logic        player_hit;
    logic [1:0]  lives;
    logic        no_lives;
    logic [15:0] score;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ah     = 0;
    int n_ph     = 0;
    int n_ru     = 0;

    always #5 pixel_clk = ~pixel_clk;

    game_event_tracker dut (
        .pixel_clk       (pixel_clk),
        .rst_n           (rst_n),
        .fsync           (fsync),
        .active_obj      (active_obj),
        .alien_id        (alien_id),
        .active_missile  (active_missile),
        .active_paddle   (active_paddle),
        .fire_btn        (fire_btn),
        .game_start      (game_start),
        .level_start     (level_start),
        .ready_up        (ready_up),
        .alien_hit       (alien_hit),
        .alien_alive     (alien_alive),
        .all_aliens_dead (all_aliens_dead),
        .player_hit      (player_hit),
        .lives           (lives),
        .no_lives        (no_lives),
        .score           (score)
    );

    // Pulse counters sampled shortly after each active edge.
    always @(posedge pixel_clk) begin
        #1;
        if (alien_hit === 1'b1)  n_ah++;
        if (player_hit === 1'b1) n_ph++;
        if (ready_up === 1'b1)   n_ru++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks begin and end on a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    task automatic do_fsync();
        fsync = 1'b1;
        @(negedge pixel_clk);
        fsync = 1'b0;
    endtask

    task automatic missile(input int id, input int n);
        active_missile = 1'b1;
        active_obj     = 1'b1;
        alien_id       = 4'(id);
        repeat (n) @(negedge pixel_clk);
        active_missile = 1'b0;
        active_obj     = 1'b0;
    endtask

    task automatic paddle(input int n);
        active_paddle = 1'b1;
        active_obj    = 1'b1;
        alien_id      = 4'd0;
        repeat (n) @(negedge pixel_clk);
        active_paddle = 1'b0;
        active_obj    = 1'b0;
    endtask

    task automatic pulse_game();
        game_start = 1'b1;
        @(negedge pixel_clk);
        game_start = 1'b0;
    endtask

    task automatic pulse_level();
        level_start = 1'b1;
        @(negedge pixel_clk);
        level_start = 1'b0;
    endtask

    task automatic fire_frame(input logic b);
        fire_btn = b;
        idle(4);
        do_fsync();
    endtask

    initial begin
        rst_n = 1'b1; fsync = 1'b0; active_obj = 1'b0; alien_id = 4'd0;
        active_missile = 1'b0; active_paddle = 1'b0; fire_btn = 1'b0;
        game_start = 1'b0; level_start = 1'b0;
        @(negedge pixel_clk);
        rst_n = 1'b0;
        idle(3);
        check_eq("rst_alive", alien_alive, 16'h0000);
        check_eq("rst_lives", lives, 2'd0);
        check_eq("rst_score", score, 16'd0);
        check_eq("rst_all_dead", all_aliens_dead, 1'b1);
        check_eq("rst_no_lives", no_lives, 1'b1);
        rst_n = 1'b1;
        idle(2);

        pulse_game();
        check_eq("gs_lives", lives, 2'd3);
        check_eq("gs_score", score, 16'd0);
        check_eq("gs_alive", alien_alive, 16'hFFFF);
        check_eq("gs_all_dead", all_aliens_dead, 1'b0);
        check_eq("gs_no_lives", no_lives, 1'b0);

        // Two aliens in one frame.
        do_fsync();
        n_ah = 0;
        idle(2); missile(5, 4); idle(2); missile(9, 1); idle(2);
        do_fsync();
        check_eq("kill_alive", alien_alive, 16'hFDDF);
        check_eq("kill_score", score, 16'd20);
        check_eq("kill_pulse_hi", alien_hit, 1'b1);
        idle(1);
        check_eq("kill_pulse_lo", alien_hit, 1'b0);
        missile(5, 4); missile(9, 1); idle(1);
        do_fsync();
        idle(1);
        check_eq("rekill_alive", alien_alive, 16'hFDDF);
        check_eq("rekill_score", score, 16'd20);
        check_eq("kill_pulse_cnt", n_ah, 1);

        // Player hits: frame 1 hit, frame 2 and 61 inside invulnerability, frame 62 hit.
        n_ph = 0;
        paddle(3); do_fsync();
        check_eq("ph1_pulse", player_hit, 1'b1);
        check_eq("ph1_lives", lives, 2'd2);
        paddle(3); do_fsync();
        check_eq("ph2_lives", lives, 2'd2);
        for (int k = 3; k <= 61; k++) begin
            idle(2);
            if (k == 61) paddle(2);
            do_fsync();
        end
        idle(1);
        check_eq("ph61_lives", lives, 2'd2);
        check_eq("ph61_cnt", n_ph, 1);
        paddle(2); do_fsync();
        check_eq("ph62_pulse", player_hit, 1'b1);
        check_eq("ph62_lives", lives, 2'd1);
        idle(1);
        check_eq("ph62_cnt", n_ph, 2);

        // Wipe the formation; 14 of 16 remain, 140 points.
        for (int i = 0; i < 16; i++) missile(i, 1);
        do_fsync();
        check_eq("wipe_all_dead", all_aliens_dead, 1'b1);
        check_eq("wipe_alive", alien_alive, 16'h0000);
        check_eq("wipe_score", score, 16'd160);

        // level_start on the fsync cycle discards the commit.
        pulse_level();
        n_ah = 0;
        missile(3, 1); missile(7, 1);
        fsync = 1'b1; level_start = 1'b1;
        @(negedge pixel_clk);
        fsync = 1'b0; level_start = 1'b0;
        check_eq("ls_alive", alien_alive, 16'hFFFF);
        check_eq("ls_score", score, 16'd160);
        do_fsync();
        idle(1);
        check_eq("ls_alive2", alien_alive, 16'hFFFF);
        check_eq("ls_no_pulse", n_ah, 0);

        // Overlap on the fsync cycle lands in the next frame.
        fsync = 1'b1; active_missile = 1'b1; active_obj = 1'b1; alien_id = 4'd2;
        @(negedge pixel_clk);
        fsync = 1'b0; active_missile = 1'b0; active_obj = 1'b0;
        check_eq("fsync_ovl_alive", alien_alive, 16'hFFFF);
        idle(2);
        do_fsync();
        check_eq("fsync_ovl_alive2", alien_alive, 16'hFFFB);
        check_eq("fsync_ovl_score", score, 16'd170);

        // Score saturates rather than wrapping.
        for (int l = 0; l < 410; l++) begin
            pulse_level();
            for (int i = 0; i < 16; i++) missile(i, 1);
            do_fsync();
            if (l == 0) check_eq("sat_first", score, 16'd330);
        end
        check_eq("sat_score", score, 16'hFFFF);

        // Debounce: 2-frame press, release, 5-frame hold, release, 3-frame press.
        idle(1);
        n_ru = 0;
        fire_frame(1'b1); fire_frame(1'b1); fire_frame(1'b0);
        fire_frame(1'b1); fire_frame(1'b1);
        check_eq("db_early", n_ru, 0);
        fire_frame(1'b1);
        check_eq("db_pulse", ready_up, 1'b1);
        fire_frame(1'b1); fire_frame(1'b1);
        idle(1);
        check_eq("db_held", n_ru, 1);
        fire_frame(1'b0);
        fire_frame(1'b1); fire_frame(1'b1); fire_frame(1'b1);
        check_eq("db_second", ready_up, 1'b1);
        idle(1);
        check_eq("db_cnt", n_ru, 2);
        fire_btn = 1'b0;

        // Last life, then collisions with no lives left.
        n_ph = 0;
        paddle(2); do_fsync();
        check_eq("last_pulse", player_hit, 1'b1);
        check_eq("last_lives", lives, 2'd0);
        check_eq("last_no_lives", no_lives, 1'b1);
        for (int k = 0; k < 62; k++) begin
            idle(1);
            do_fsync();
        end
        paddle(2); do_fsync();
        idle(1);
        check_eq("zero_lives", lives, 2'd0);
        check_eq("zero_no_pulse", n_ph, 1);

        // Reset with kills pending.
        pulse_game();
        missile(4, 2);
        rst_n = 1'b0;
        #1;
        check_eq("arst_alive", alien_alive, 16'h0000);
        check_eq("arst_lives", lives, 2'd0);
        check_eq("arst_score", score, 16'd0);
        @(negedge pixel_clk);
        rst_n = 1'b1;
        n_ah = 0; n_ph = 0;
        idle(1); do_fsync(); idle(2); do_fsync(); idle(1);
        check_eq("arst_no_hit", n_ah + n_ph, 0);
        check_eq("arst_alive2", alien_alive, 16'h0000);
        check_eq("arst_score2", score, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
